// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter and sequencer for a single-ported unified memory.
// Requester 0 is the core (fetch/load/store). Requester 1 is the DMA/program loader.
// One transaction at a time. The winning command is latched and driven to memory
// until mem_ready arrives or the wait budget runs out. The requester then gets a
// one-cycle ack together with its read data.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cpu_req/we/addr/wdata       core command, held until cpu_ack
//   cpu_rdata, cpu_ack          core read data, valid with the one-cycle ack
//   cpu_stall                   cpu_req & ~cpu_ack (combinational freeze for the core)
//   dma_req/we/addr/wdata       DMA command, held until dma_ack
//   dma_rdata, dma_ack          DMA read data, valid with the one-cycle ack
//   mem_en/we/addr/wdata        registered memory command
//   mem_rdata, mem_ready        memory response
//   timeout_err                 sticky: an access was aborted after MAX_WAIT waits
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no access in flight; arbitrate between eligible requesters
// CPU_BUSY | core access on the memory bus; wait for mem_ready or timeout
// DMA_BUSY | DMA access on the memory bus; wait for mem_ready or timeout

module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              timeout_err
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_BUSY = 2'd1,
    DMA_BUSY = 2'd2
  } state_t;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DMA = 1'b1;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dma_ack_q, dma_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

  logic cpu_elig;
  logic dma_elig;
  logic wait_expired;

  // A requester whose ack is high this cycle still shows its old req; it must
  // not be granted again on the strength of that stale request.
  assign cpu_elig     = cpu_req & ~cpu_ack_q;
  assign dma_elig     = dma_req & ~dma_ack_q;
  assign wait_expired = (wait_cnt_q == CNT_W'(MAX_WAIT));

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cpu_ack_d     = 1'b0;
    dma_ack_d     = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    dma_rdata_d   = dma_rdata_q;
    mem_en_d      = mem_en_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    timeout_err_d = timeout_err_q;
    wait_cnt_d    = wait_cnt_q;

    case (state_q)
      IDLE: begin
        // Round-robin on a tie: the requester not served last wins.
        if (cpu_elig && (!dma_elig || last_grant_q == GRANT_DMA)) begin
          state_d      = CPU_BUSY;
          last_grant_d = GRANT_CPU;
          mem_en_d     = 1'b1;
          mem_we_d     = cpu_we;
          mem_addr_d   = cpu_addr;
          mem_wdata_d  = cpu_wdata;
          wait_cnt_d   = '0;
        end else if (dma_elig) begin
          state_d      = DMA_BUSY;
          last_grant_d = GRANT_DMA;
          mem_en_d     = 1'b1;
          mem_we_d     = dma_we;
          mem_addr_d   = dma_addr;
          mem_wdata_d  = dma_wdata;
          wait_cnt_d   = '0;
        end
      end

      CPU_BUSY, DMA_BUSY: begin
        if (mem_ready || wait_expired) begin
          state_d  = IDLE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (state_q == CPU_BUSY) begin
            cpu_ack_d = 1'b1;
          end else begin
            dma_ack_d = 1'b1;
          end
          // mem_ready on the last allowed cycle still counts as success.
          if (mem_ready) begin
            if (!mem_we_q) begin
              if (state_q == CPU_BUSY) begin
                cpu_rdata_d = mem_rdata;
              end else begin
                dma_rdata_d = mem_rdata;
              end
            end
          end else begin
            timeout_err_d = 1'b1;
            if (state_q == CPU_BUSY) begin
              cpu_rdata_d = '0;
            end else begin
              dma_rdata_d = '0;
            end
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= GRANT_DMA;
      cpu_ack_q     <= 1'b0;
      dma_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      dma_rdata_q   <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      timeout_err_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cpu_ack_q     <= cpu_ack_d;
      dma_ack_q     <= dma_ack_d;
      cpu_rdata_q   <= cpu_rdata_d;
      dma_rdata_q   <= dma_rdata_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      timeout_err_q <= timeout_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign cpu_ack     = cpu_ack_q;
  assign dma_ack     = dma_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign dma_rdata   = dma_rdata_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign timeout_err = timeout_err_q;
  assign cpu_stall   = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a per-cycle vector table for arbitration, latency
// and wait states, then hand sequences for the timeout boundary, the sticky
// error, a request dropped mid-access and a reset during a DMA access.

module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dma_req, dma_we, mem_ready;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          cpu_ack, cpu_stall, dma_ack, mem_en, mem_we, timeout_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        rst;
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic        dreq, dwe;
    logic [31:0] daddr, dwd;
    logic        rdy;
    logic [31:0] mrd;
    logic        e_cack, e_cstall;
    logic [31:0] e_crd;
    logic        e_dack;
    logic [31:0] e_drd;
    logic        e_en, e_we;
    logic [31:0] e_maddr, e_mwd;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic r, logic cq, logic cw, logic [31:0] ca, logic [31:0] cd,
    logic dq, logic dw, logic [31:0] da, logic [31:0] dd,
    logic rd, logic [31:0] mr,
    logic eca, logic est, logic [31:0] ecr, logic eda, logic [31:0] edr,
    logic een, logic ewe, logic [31:0] ema, logic [31:0] emw, logic eer);
    vec_t v;
    v.rst = r; v.creq = cq; v.cwe = cw; v.caddr = ca; v.cwd = cd;
    v.dreq = dq; v.dwe = dw; v.daddr = da; v.dwd = dd; v.rdy = rd; v.mrd = mr;
    v.e_cack = eca; v.e_cstall = est; v.e_crd = ecr; v.e_dack = eda; v.e_drd = edr;
    v.e_en = een; v.e_we = ewe; v.e_maddr = ema; v.e_mwd = emw; v.e_err = eer;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic inputs_idle();
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    // rst | core cmd | dma cmd | mem resp || cack stall crdata | dack drdata | en we addr wdata | err
    // single core read
    vecs.push_back(mk(0, 1,0,32'h100,32'hDEAD0001, 0,0,0,0, 0,0,                       0,1,0, 0,0, 0,0,0,0, 0));
    vecs.push_back(mk(0, 1,0,32'h100,32'hDEAD0001, 0,0,0,0, 1,32'hA5A5A5A5,            0,1,0, 0,0, 1,0,32'h100,32'hDEAD0001, 0));
    vecs.push_back(mk(0, 1,0,32'h100,32'hDEAD0001, 0,0,0,0, 0,0,                       1,0,32'hA5A5A5A5, 0,0, 0,0,32'h100,32'hDEAD0001, 0));
    vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,                                        0,0,32'hA5A5A5A5, 0,0, 0,0,32'h100,32'hDEAD0001, 0));
    // reset, then both request with memory always ready
    vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,                                        0,0,32'hA5A5A5A5, 0,0, 0,0,32'h100,32'hDEAD0001, 0));
    vecs.push_back(mk(0, 1,1,32'h200,32'h11111111, 1,0,32'h300,32'h22222222, 1,32'h33333333, 0,1,0, 0,0, 0,0,0,0, 0));
    vecs.push_back(mk(0, 1,1,32'h200,32'h11111111, 1,0,32'h300,32'h22222222, 1,32'h33333333, 0,1,0, 0,0, 1,1,32'h200,32'h11111111, 0));
    vecs.push_back(mk(0, 1,0,32'h204,32'h55555555, 1,0,32'h300,32'h22222222, 1,32'h33333333, 1,0,0, 0,0, 0,0,32'h200,32'h11111111, 0));
    vecs.push_back(mk(0, 1,0,32'h204,32'h55555555, 1,0,32'h300,32'h22222222, 1,32'h44444444, 0,1,0, 0,0, 1,0,32'h300,32'h22222222, 0));
    vecs.push_back(mk(0, 1,0,32'h204,32'h55555555, 1,0,32'h300,32'h22222222, 1,32'h44444444, 0,1,0, 1,32'h44444444, 0,0,32'h300,32'h22222222, 0));
    vecs.push_back(mk(0, 1,0,32'h204,32'h55555555, 0,0,0,0, 1,32'h66666666,            0,1,0, 0,32'h44444444, 1,0,32'h204,32'h55555555, 0));
    vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,                                        1,0,32'h66666666, 0,32'h44444444, 0,0,32'h204,32'h55555555, 0));
    // DMA write with 4 wait states; DMA inputs change during BUSY and must be ignored
    vecs.push_back(mk(0, 0,0,0,0, 1,1,32'h40,32'h12345678, 0,0,                        0,0,32'h66666666, 0,32'h44444444, 0,0,32'h204,32'h55555555, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0,0,0,0, 1,1,32'hFFFF0000,0, 0,32'hBAD0BAD0,                0,0,32'h66666666, 0,32'h44444444, 1,1,32'h40,32'h12345678, 0));
    vecs.push_back(mk(0, 0,0,0,0, 1,1,32'hFFFF0000,0, 1,32'hBAD0BAD0,                  0,0,32'h66666666, 0,32'h44444444, 1,1,32'h40,32'h12345678, 0));
    vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,                                        0,0,32'h66666666, 1,32'h44444444, 0,0,32'h40,32'h12345678, 0));
    vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,                                        0,0,32'h66666666, 0,32'h44444444, 0,0,32'h40,32'h12345678, 0));

    inputs_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      next_cycle();
      rst = vecs[i].rst;
      cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe; cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
      dma_req = vecs[i].dreq; dma_we = vecs[i].dwe; dma_addr = vecs[i].daddr; dma_wdata = vecs[i].dwd;
      mem_ready = vecs[i].rdy; mem_rdata = vecs[i].mrd;
      #1;
      chk($sformatf("v%0d cpu_ack", i), cpu_ack, vecs[i].e_cack);
      chk($sformatf("v%0d cpu_stall", i), cpu_stall, vecs[i].e_cstall);
      chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vecs[i].e_crd);
      chk($sformatf("v%0d dma_ack", i), dma_ack, vecs[i].e_dack);
      chk($sformatf("v%0d dma_rdata", i), dma_rdata, vecs[i].e_drd);
      chk($sformatf("v%0d mem_en", i), mem_en, vecs[i].e_en);
      chk($sformatf("v%0d mem_we", i), mem_we, vecs[i].e_we);
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_mwd);
      chk($sformatf("v%0d timeout_err", i), timeout_err, vecs[i].e_err);
    end

    // mem_ready arriving on the MAX_WAIT cycle is a normal completion
    next_cycle(); inputs_idle();
    cpu_req = 1'b1; cpu_addr = 32'h500; #1;
    chk("edge req mem_en", mem_en, 0);
    for (int i = 0; i < MW; i++) begin
      next_cycle(); #1;
      chk($sformatf("edge wait%0d mem_en", i), mem_en, 1);
      chk($sformatf("edge wait%0d cpu_ack", i), cpu_ack, 0);
    end
    next_cycle(); mem_ready = 1'b1; mem_rdata = 32'h0F0F0F0F; #1;
    chk("edge last mem_en", mem_en, 1);
    next_cycle(); inputs_idle(); #1;
    chk("edge cpu_ack", cpu_ack, 1);
    chk("edge cpu_rdata", cpu_rdata, 32'h0F0F0F0F);
    chk("edge timeout_err", timeout_err, 0);

    // timeout: MAX_WAIT+1 BUSY cycles then an ack with zero data and a sticky error
    next_cycle(); inputs_idle();
    cpu_req = 1'b1; cpu_addr = 32'h600; #1;
    chk("to idle cpu_ack", cpu_ack, 0);
    for (int i = 0; i <= MW; i++) begin
      next_cycle(); #1;
      chk($sformatf("to busy%0d mem_en", i), mem_en, 1);
      chk($sformatf("to busy%0d cpu_ack", i), cpu_ack, 0);
      chk($sformatf("to busy%0d timeout_err", i), timeout_err, 0);
    end
    next_cycle(); inputs_idle(); #1;
    chk("to cpu_ack", cpu_ack, 1);
    chk("to cpu_rdata", cpu_rdata, 0);
    chk("to timeout_err", timeout_err, 1);
    chk("to mem_en", mem_en, 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      chk($sformatf("to sticky%0d", i), timeout_err, 1);
      chk($sformatf("to quiet%0d cpu_ack", i), cpu_ack, 0);
    end
    next_cycle(); dma_req = 1'b1; dma_addr = 32'h700; #1;
    next_cycle(); mem_ready = 1'b1; mem_rdata = 32'h77; #1;
    chk("to dma mem_addr", mem_addr, 32'h700);
    next_cycle(); inputs_idle(); #1;
    chk("to dma_ack", dma_ack, 1);
    chk("to dma_rdata", dma_rdata, 32'h77);
    chk("to sticky after dma", timeout_err, 1);

    // core request dropped during BUSY: the write still completes with a single ack
    next_cycle(); inputs_idle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h800; cpu_wdata = 32'hCAFEF00D; #1;
    next_cycle(); inputs_idle(); #1;
    chk("drop mem_en", mem_en, 1);
    chk("drop mem_we", mem_we, 1);
    chk("drop mem_addr", mem_addr, 32'h800);
    chk("drop mem_wdata", mem_wdata, 32'hCAFEF00D);
    chk("drop cpu_stall", cpu_stall, 0);
    next_cycle(); #1;
    chk("drop wait mem_en", mem_en, 1);
    next_cycle(); mem_ready = 1'b1; mem_rdata = 32'h99999999; #1;
    chk("drop ready mem_en", mem_en, 1);
    next_cycle(); inputs_idle(); #1;
    chk("drop cpu_ack", cpu_ack, 1);
    chk("drop cpu_rdata", cpu_rdata, 0);
    chk("drop mem_en after", mem_en, 0);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); #1;
      chk($sformatf("drop post%0d cpu_ack", i), cpu_ack, 0);
      chk($sformatf("drop post%0d mem_en", i), mem_en, 0);
    end

    // reset during DMA_BUSY: access lost, no ack, then a normal core access
    next_cycle(); inputs_idle();
    dma_req = 1'b1; dma_addr = 32'h900; #1;
    next_cycle(); #1;
    chk("rst busy mem_en", mem_en, 1);
    chk("rst busy mem_addr", mem_addr, 32'h900);
    next_cycle(); inputs_idle(); rst = 1'b1; #1;
    chk("rst cycle mem_en", mem_en, 1);
    next_cycle(); inputs_idle(); #1;
    chk("rst after mem_en", mem_en, 0);
    chk("rst after dma_ack", dma_ack, 0);
    chk("rst after timeout_err", timeout_err, 0);
    chk("rst after mem_addr", mem_addr, 0);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); #1;
      chk($sformatf("rst quiet%0d dma_ack", i), dma_ack, 0);
      chk($sformatf("rst quiet%0d mem_en", i), mem_en, 0);
    end
    next_cycle(); cpu_req = 1'b1; cpu_addr = 32'hA00; #1;
    chk("rst core stall", cpu_stall, 1);
    next_cycle(); mem_ready = 1'b1; mem_rdata = 32'hABCDEF01; #1;
    chk("rst core mem_en", mem_en, 1);
    chk("rst core mem_addr", mem_addr, 32'hA00);
    next_cycle(); inputs_idle(); #1;
    chk("rst core cpu_ack", cpu_ack, 1);
    chk("rst core cpu_rdata", cpu_rdata, 32'hABCDEF01);
    chk("rst core dma_ack", dma_ack, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
